dotp_sched: RTL
===============

// Module: dotp_sched
// PURPOSE
//  Shares one fixed-latency FP32 dot-product engine between NREQ requesters. Round-robin grants one vector pair per cycle,
//  tracks in-flight ops with an ID shift pipe, and buffers results in a credit-protected FIFO, because the engine cannot stall.
//  Sits between the requester ports and the dot-product engine.
// PARAMETERS
//  NREQ       4  number of requesters (>=2)
//  VSIZE      4  vector length (words per operand)
//  ENG_LAT    4  cycles from issue (eng_vld=1 at edge N) to eng_result valid at edge N+ENG_LAT
//  FIFO_DEPTH 8  result FIFO entries (>=ENG_LAT, power of 2)
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              async active-low reset
//  req_valid  in   NREQ           requester i has an operand pair
//  req_ready  out  NREQ           one-hot grant; transfer when valid&ready
//  req_in1    in   NREQ*VSIZE*32  operand A per requester
//  req_in2    in   NREQ*VSIZE*32  operand B per requester
//  eng_vld    out  1              issue strobe to engine
//  eng_in1    out  VSIZE*32       registered operand A to engine
//  eng_in2    out  VSIZE*32       registered operand B to engine
//  eng_result in   32             engine dot product, ENG_LAT after issue
//  rsp_valid  out  1              FIFO not empty
//  rsp_ready  in   1              consumer accepts
//  rsp_data   out  32             dot-product result
//  rsp_id     out  $clog2(NREQ)   originating requester
//  busy       out  1              in-flight ops or FIFO non-empty
// BEHAVIOUR
//  Reset: rst_n async, active-low; clock clk. req_ready=0, eng_vld=0, eng_in*=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   busy=0. RR pointer=NREQ-1 (so req 0 wins first). ID pipe and FIFO are empty.
//  Credit: inflight = count of valid ID-pipe stages; fifo_cnt = FIFO occupancy; issue allowed iff
//   inflight+fifo_cnt < FIFO_DEPTH, using registered values. A pop in the same cycle does not free credit that cycle.
//  Grant (combinational): if credit ok, req_ready = one-hot of the first asserted req_valid searching ptr+1..ptr wrapping.
//   Otherwise req_ready=0. At most one bit set. ptr <= granted index, updated only on grant.
//  Issue: on grant edge, eng_in1/eng_in2 <= granted operands, eng_vld<=1, id pipe stage0 <= {1,idx}. Otherwise eng_vld<=0
//   and eng_in* hold their value.
//  ID pipe: ENG_LAT-1 registered stages after stage0. When the last stage is valid, {eng_result, id} is pushed to the
//   FIFO that cycle. Credit guarantees no overflow; overflow is an assertion failure.
//  FIFO: pop when rsp_valid&rsp_ready. rsp_data and rsp_id come from the FIFO head (show-ahead).
//   Simultaneous push+pop keeps fifo_cnt unchanged, including when full. Pointers wrap modulo FIFO_DEPTH.
//  Throughput: 1 op/cycle sustained when rsp_ready=1; first response 1+ENG_LAT cycles after grant.
//  Ordering: responses are returned strictly in issue order.
//  busy = |idpipe_valid | (fifo_cnt!=0).
//  Reset mid-operation: all in-flight ops and FIFO contents are discarded; a late engine output is ignored.
// CONFIGURATION
//  DOTP_SCHED_PERF_EN defined: adds outputs perf_issued[31:0] (grants) and perf_stall[31:0] (cycles with any
//   req_valid but no grant due to credit). Both reset to 0, wrap at 2^32.
//  Undefined: neither port nor counter logic exists.
// STRUCTURE
//  dotp_pkg: typedef logic[31:0] word_t; typedef word_t [VSIZE-1:0] vec_t; function clog2_min1 for ID width.
//  Sub-module dotp_rr_arb: parameter NREQ; inputs req, en; outputs one-hot gnt and gnt_idx; owns the RR pointer.
//  FIFO and ID pipe stay inline.
// TESTING
//  Reset then req_valid=4'b0001 with one pair {1.0,2.0,3.0,4.0}.{1,1,1,1} -> eng_vld one cycle;
//   rsp_valid 1+ENG_LAT cycles later, rsp_data=0x41200000 (10.0), rsp_id=0.
//  All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id follows the same sequence.
//  rsp_ready=0, req_valid=4'b1111 -> exactly 8 grants, then req_ready=0 and busy=1.
//   One rsp_ready pulse -> one more grant the next cycle.
//  FIFO full with simultaneous push+pop -> fifo_cnt stays 8, no data lost; the sequence of 8 results matches the model.
//  rst_n asserted with 3 in-flight and 5 buffered -> outputs go to reset values immediately;
//   after release no stale rsp_valid appears.
//  With DOTP_SCHED_PERF_EN, run the full-FIFO scenario for 20 cycles -> perf_issued=8, perf_stall=12.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared types and helpers for the dot-product scheduler slice.
package dotp_pkg;

    localparam int DOTP_VSIZE = 4;

    typedef logic [31:0]               word_t;
    typedef word_t [DOTP_VSIZE-1:0]    vec_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dotp_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request after the last winner.
module dotp_rr_arb
    import dotp_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_cand;
    logic           w_found;

    // Search ptr+1 .. ptr (wrapping) for the first asserted request.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDW'((int'(r_ptr) + i) % NREQ);
            if (en && !w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

    // Pointer follows the winner; starts at NREQ-1 so requester 0 wins first.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (|gnt) begin
            r_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/dotp_sched.sv
// Scheduler sharing one fixed-latency FP32 dot-product engine between NREQ requesters.
// Optional perf counters are built when DOTP_SCHED_PERF_EN is defined.
module dotp_sched
    import dotp_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int VSIZE      = 4,
    parameter  int ENG_LAT    = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int IDW        = clog2_min1(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*VSIZE*32-1:0] req_in1,
    input  logic [NREQ*VSIZE*32-1:0] req_in2,
    output logic                    eng_vld,
    output logic [VSIZE*32-1:0]     eng_in1,
    output logic [VSIZE*32-1:0]     eng_in2,
    input  logic [31:0]             eng_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
`ifdef DOTP_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall
`endif
);

    localparam int              OPW      = VSIZE * 32;
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    logic [OPW-1:0]   w_in1 [NREQ];
    logic [OPW-1:0]   w_in2 [NREQ];
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_grant;
    logic             w_credit_ok;
    logic             w_arb_en;
    int               w_inflight;
    logic             w_push;
    logic             w_pop;

    logic             r_eng_vld;
    logic [OPW-1:0]   r_eng_in1;
    logic [OPW-1:0]   r_eng_in2;
    logic [ENG_LAT-1:0] r_pipe_vld;
    logic [IDW-1:0]   r_pipe_id [ENG_LAT];
    word_t            r_fifo_data [FIFO_DEPTH];
    logic [IDW-1:0]   r_fifo_id   [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_fifo_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_in1[g] = req_in1[g*OPW +: OPW];
        assign w_in2[g] = req_in2[g*OPW +: OPW];
    end

    // Credit counts every op between issue and pop, so the FIFO can always absorb the engine output.
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < ENG_LAT; i++) begin
            w_inflight += int'(r_pipe_vld[i]);
        end
    end

    assign w_credit_ok = (w_inflight + int'(r_fifo_cnt)) < FIFO_DEPTH;
    // Held off during reset so req_ready reads 0 as soon as rst_n drops.
    assign w_arb_en    = w_credit_ok & rst_n;
    assign w_grant     = |w_gnt;
    assign req_ready   = w_gnt;

    dotp_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Register the granted operand pair toward the engine; operands hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eng_vld <= 1'b0;
            r_eng_in1 <= '0;
            r_eng_in2 <= '0;
        end else begin
            r_eng_vld <= w_grant;
            if (w_grant) begin
                r_eng_in1 <= w_in1[w_gnt_idx];
                r_eng_in2 <= w_in2[w_gnt_idx];
            end
        end
    end

    assign eng_vld = r_eng_vld;
    assign eng_in1 = r_eng_in1;
    assign eng_in2 = r_eng_in2;

    // Valid bits of the ID pipe track ops inside the engine; reset drops them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
        end else begin
            for (int i = ENG_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            r_pipe_vld[0] <= w_grant;
        end
    end

    // Requester IDs ride alongside the valid bits; the valid bit qualifies them.
    // NOTE: data-only storage (ID pipe, FIFO array) has no reset; valid bits and pointers make stale contents invisible.
    always_ff @(posedge clk) begin
        for (int i = ENG_LAT - 1; i > 0; i--) begin
            r_pipe_id[i] <= r_pipe_id[i-1];
        end
        r_pipe_id[0] <= w_gnt_idx;
    end

    assign w_push = r_pipe_vld[ENG_LAT-1];
    assign w_pop  = rsp_valid & rsp_ready;

    // Capture the engine result with its requester ID as the op leaves the pipe.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= eng_result;
            r_fifo_id[r_wr_ptr]   <= r_pipe_id[ENG_LAT-1];
        end
    end

    // FIFO pointers and occupancy; push+pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign rsp_valid = (r_fifo_cnt != '0);
    assign rsp_data  = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? r_fifo_id[r_rd_ptr]   : '0;
    assign busy      = (|r_pipe_vld) | rsp_valid;

`ifdef DOTP_SCHED_PERF_EN
    // Count grants, and cycles where a request waits only because credit is exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_grant)                     perf_issued <= perf_issued + 1'b1;
            if (|req_valid && !w_credit_ok)  perf_stall  <= perf_stall + 1'b1;
        end
    end
`else
    // Build without performance counters: no ports, no counter state.
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_fifo_cnt == FULL_CNT));

endmodule
